dma_arbiter: RTL and testbench



---
 rtl/dma_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_dma_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// -----------------------------------------------------------------------------
// dma_arbiter
//
// Shares one word-wide SDRAM/DMA memory port between NUM_REQ peripheral DMA
// requesters (USB = id 0, SD = id 1, later engines above). Arbitration is
// round-robin with a bounded burst lock: the requester that last won keeps
// the port for up to MAX_BURST consecutive words while it keeps requesting.
//
// Optional feature (compile-time macro DMA_ARBITER_TIMEOUT_EN):
//   defined   - an access with no mem_ack for TIMEOUT cycles is aborted with
//               ack + error, and the offender loses its burst lock.
//   undefined - no timeout logic; error is always 0 and ACCESS waits forever.
//
// Ports:
//   clk, reset        system clock; synchronous active-low reset
//   req[NUM_REQ]      per-requester request, held until its ack
//   write[NUM_REQ]    per-requester direction (1 = write)
//   addr              packed word addresses, requester i at [32i+31:32i]
//   wdata             packed write data, requester i at [16i+15:16i]
//   ack[NUM_REQ]      one-cycle completion pulse to the granted requester
//   rdata             read data, valid in the ack cycle
//   error             abort flag, valid with ack
//   grant_id          current / last granted requester index
//   busy              high while an access is in flight
//   mem_req/mem_write/mem_addr/mem_wdata   memory-side request fields
//   mem_ack/mem_rdata memory-side single-cycle completion and read data
//
// Handshake: a requester raises req with write/addr/wdata stable and keeps
// them so until it sees ack for one cycle; the arbiter samples req again
// one cycle after ack (DONE), so the requester may drop req or present the
// next word in the ack cycle. On the memory side mem_req and its fields stay
// stable until the single-cycle mem_ack; mem_ack outside ACCESS is ignored.
// -----------------------------------------------------------------------------
module dma_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    write,
    input  logic [NUM_REQ*32-1:0] addr,
    input  logic [NUM_REQ*16-1:0] wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [15:0]           rdata,
    output logic                  error,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [31:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 256 ||
        TIMEOUT < 1) begin : g_bad_param
        $error("dma_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [2:0]  ptr, ptr_d;
    logic [2:0]  grant_d;
    logic [8:0]  burst_cnt, burst_d;
    logic        busy_d;
    logic        mem_req_d;
    logic        mem_write_d;
    logic [31:0] mem_addr_d;
    logic [15:0] mem_wdata_d;
    logic [15:0] rdata_d;
    logic        error_d;
    logic [NUM_REQ-1:0] ack_d;

`ifdef DMA_ARBITER_TIMEOUT_EN
    logic [31:0] to_cnt, to_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic [7:0]  req_ext;
    logic [2:0]  scan_w;
    logic        scan_found;
    logic [2:0]  win;
    logic [8:0]  win_burst;

    always_comb begin
        req_ext    = 8'(req);
        scan_w     = ptr;
        scan_found = 1'b0;
        // First asserted request strictly after the pointer, wrapping.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!scan_found && req_ext[3'((int'(ptr) + k) % NUM_REQ)]) begin
                scan_w     = 3'((int'(ptr) + k) % NUM_REQ);
                scan_found = 1'b1;
            end
        end
        if ((burst_cnt < 9'(MAX_BURST)) && req_ext[grant_id]) begin
            // Burst lock: the last winner keeps the port.
            win       = grant_id;
            win_burst = burst_cnt;
        end else begin
            // Forced or natural re-arbitration; a sole requester simply
            // wins again with a fresh burst count.
            win       = scan_w;
            win_burst = 9'd0;
        end
    end

    logic        sel_write;
    logic [31:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [NUM_REQ-1:0] grant_onehot;

    always_comb begin
        sel_write    = 1'b0;
        sel_addr     = 32'd0;
        sel_wdata    = 16'd0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) begin
                sel_write = write[i];
                sel_addr  = addr[32*i +: 32];
                sel_wdata = wdata[16*i +: 16];
            end
            grant_onehot[i] = (grant_id == 3'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        grant_d     = grant_id;
        burst_d     = burst_cnt;
        busy_d      = busy;
        mem_req_d   = mem_req;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata_d     = rdata;
        ack_d       = '0;       // ack and error are single-cycle pulses
        error_d     = 1'b0;
`ifdef DMA_ARBITER_TIMEOUT_EN
        to_cnt_d    = to_cnt;
`endif

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (|req) begin
                    // The pointer always follows the winner so the next
                    // forced rotation starts just after whoever held the
                    // port, including the very first grant after reset.
                    ptr_d       = win;
                    grant_d     = win;
                    burst_d     = win_burst;
                    mem_req_d   = 1'b1;
                    mem_write_d = sel_write;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    busy_d      = 1'b1;
                    state_d     = ACCESS;
`ifdef DMA_ARBITER_TIMEOUT_EN
                    to_cnt_d    = 32'd0;
`endif
                end
            end

            ACCESS: begin
                if (mem_ack) begin
                    // A mem_ack coinciding with expiry wins.
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                    ack_d     = grant_onehot;
                    state_d   = DONE;
                end
`ifdef DMA_ARBITER_TIMEOUT_EN
                else if (to_cnt == 32'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    rdata_d   = 16'd0;
                    ack_d     = grant_onehot;
                    error_d   = 1'b1;
                    // Exhaust the burst so the offender loses the lock.
                    burst_d   = 9'(MAX_BURST);
                    state_d   = DONE;
                end else begin
                    to_cnt_d = to_cnt + 32'd1;
                end
`endif
            end

            DONE: begin
                busy_d  = 1'b0;
                burst_d = (burst_cnt == 9'h1FF) ? burst_cnt : burst_cnt + 9'd1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 3'(NUM_REQ - 1);
            grant_id  <= 3'd0;
            burst_cnt <= 9'd0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 16'd0;
            rdata     <= 16'd0;
            ack       <= '0;
            error     <= 1'b0;
`ifdef DMA_ARBITER_TIMEOUT_EN
            to_cnt    <= 32'd0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            grant_id  <= grant_d;
            burst_cnt <= burst_d;
            busy      <= busy_d;
            mem_req   <= mem_req_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rdata     <= rdata_d;
            ack       <= ack_d;
            error     <= error_d;
`ifdef DMA_ARBITER_TIMEOUT_EN
            to_cnt    <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_arbiter
//
// Self-checking bench for dma_arbiter (NUM_REQ=2, MAX_BURST=4, TIMEOUT=8).
// Directed scenarios push their hand-derived grant order into scoreboard
// queues; a monitor pops and compares on every new memory request and every
// ack. The timeout scenario runs only when DMA_ARBITER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dma_arbiter;

    localparam int NR = 2;
    localparam int MB = 4;
    localparam int TO = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    initial forever #5 clk = ~clk;

    // DUT signals
    logic [NR-1:0]    req;
    logic [NR-1:0]    write;
    logic [NR*32-1:0] addr;
    logic [NR*16-1:0] wdata;
    logic [NR-1:0]    ack;
    logic [15:0]      rdata;
    logic             error;
    logic [2:0]       grant_id;
    logic             busy;
    logic             mem_req;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic             mem_ack;
    logic [15:0]      mem_rdata;

    dma_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .error(error),
        .grant_id(grant_id), .busy(busy), .mem_req(mem_req),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // scoreboard: {id[2:0], error, rdata[15:0]} and {id, write, addr, wdata}
    logic [19:0] exp_q[$];
    logic [51:0] grant_q[$];
    int checks = 0;
    int errors = 0;

    // requester agent configuration and memory model controls
    int          words[NR];
    int          done_w[NR];
    int          gap[NR];
    int          start_dly[NR];
    bit          hold[NR];
    logic        wr_flag[NR];
    logic [31:0] base[NR];
    int          exp_w[NR];
    int          mem_delay;
    int          slow_n;
    bit          mem_force;
    bit          period_chk;

    function automatic logic [31:0] word_addr(input int i, input int k);
        return base[i] + 32'(k);
    endfunction

    function automatic logic [15:0] word_wdata(input int i, input int k);
        return {4'(i + 1), 12'(k)};
    endfunction

    // Memory contents: chosen so address 0x100 reads back 0xBEEF.
    function automatic logic [15:0] mem_resp(input logic [31:0] a);
        return a[15:0] ^ 16'hBFEF;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_grant(input int id);
        int k;
        k = exp_w[id];
        grant_q.push_back({3'(id), wr_flag[id], word_addr(id, k), word_wdata(id, k)});
    endtask

    task automatic push_expected(input int id, input bit err);
        int k;
        k = exp_w[id];
        push_grant(id);
        exp_q.push_back({3'(id), err, err ? 16'h0000 : mem_resp(word_addr(id, k))});
        exp_w[id] = k + 1;
    endtask

    task automatic present(input int i);
        write[i]            = wr_flag[i];
        addr[i*32 +: 32]    = word_addr(i, done_w[i]);
        wdata[i*16 +: 16]   = word_wdata(i, done_w[i]);
        req[i]              = 1'b1;
    endtask

    // Drives both requesters cycle by cycle until all words are acked.
    task automatic run_traffic(input int budget);
        int  n;
        bit  all_done;
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            for (int i = 0; i < NR; i++) begin
                if (req[i] && ack[i]) begin
                    done_w[i]++;
                    if (hold[i] && done_w[i] < words[i]) present(i);
                    else begin
                        req[i] = 1'b0;
                        gap[i] = 1;
                    end
                end else if (!req[i] && done_w[i] < words[i]) begin
                    if (start_dly[i] > 0)  start_dly[i]--;
                    else if (gap[i] > 0)   gap[i]--;
                    else                   present(i);
                end
            end
            all_done = (exp_q.size() == 0) && (grant_q.size() == 0);
            for (int i = 0; i < NR; i++)
                if (done_w[i] < words[i]) all_done = 1'b0;
            if (all_done) begin
                check_val("traffic_complete", 64'd1, 64'd1);
                break;
            end
            if (n >= budget) begin
                check_val("traffic_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = '0;
        write     = '0;
        addr      = '0;
        wdata     = '0;
        mem_delay = 0;
        slow_n    = 0;
        mem_force = 1'b0;
        period_chk = 1'b0;
        for (int i = 0; i < NR; i++) begin
            words[i] = 0; done_w[i] = 0; gap[i] = 0; start_dly[i] = 0;
            hold[i] = 1'b0; wr_flag[i] = 1'b0; base[i] = 32'd0; exp_w[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ack",       64'(ack),       64'd0);
        check_val("rst_rdata",     64'(rdata),     64'd0);
        check_val("rst_error",     64'(error),     64'd0);
        check_val("rst_grant_id",  64'(grant_id),  64'd0);
        check_val("rst_busy",      64'(busy),      64'd0);
        check_val("rst_mem_req",   64'(mem_req),   64'd0);
        check_val("rst_mem_write", 64'(mem_write), 64'd0);
        check_val("rst_mem_addr",  64'(mem_addr),  64'd0);
        check_val("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b1;
    endtask

    // memory model
    initial begin
        int wait_n;
        bit acked;
        bit in_access;
        int access_n;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        wait_n = 0; acked = 1'b0; in_access = 1'b0; access_n = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!reset) begin
                wait_n = 0; acked = 1'b0; in_access = 1'b0; access_n = 0;
            end else if (mem_force) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (mem_req) begin
                in_access = 1'b1;
                if (!acked && access_n >= slow_n) begin
                    if (wait_n >= mem_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_resp(mem_addr);
                        acked     = 1'b1;
                    end else begin
                        wait_n++;
                    end
                end
            end else begin
                if (in_access) access_n++;
                in_access = 1'b0; wait_n = 0; acked = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        int          cyc;
        int          grant_cyc;
        int          last_ack;
        logic        mreq_prev;
        logic        mack_prev;
        logic [19:0] e;
        logic [51:0] g;
        cyc = 0; grant_cyc = 0; last_ack = -1; mreq_prev = 1'b0; mack_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!period_chk) last_ack = -1;
            if (reset && mem_req && !mreq_prev) begin
                if (grant_q.size() == 0) check_val("unexpected_grant", 64'(mem_addr), 64'hFFFF_FFFF);
                else begin
                    g = grant_q.pop_front();
                    check_val("grant", {12'd0, grant_id, mem_write, mem_addr, mem_wdata}, {12'd0, g});
                end
                grant_cyc = cyc;
            end
            if (|ack) begin
                if (exp_q.size() == 0) check_val("unexpected_ack", 64'(ack), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check_val("ack_vec", 64'(ack), 64'(NR'(1) << e[19:17]));
                    check_val("rdata",   64'(rdata), 64'(e[15:0]));
                    check_val("error",   64'(error), 64'(e[16]));
                    if (e[16]) check_val("timeout_latency", 64'(cyc - grant_cyc), 64'(TO));
                    else       check_val("ack_latency", 64'(mack_prev), 64'd1);
                end
                if (period_chk) begin
                    if (last_ack >= 0) check_val("word_period", 64'(cyc - last_ack), 64'd3);
                    last_ack = cyc;
                end
            end
            mreq_prev = mem_req;
            mack_prev = mem_ack;
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int ord[$];

        // 1: single read, mem_ack two cycles into ACCESS
        do_reset();
        words[0] = 1; base[0] = 32'h100; mem_delay = 2;
        push_expected(0, 1'b0);
        present(0);
        @(posedge clk); #1;
        check_val("t1_mem_req",  64'(mem_req),  64'd1);
        check_val("t1_mem_addr", 64'(mem_addr), 64'h100);
        check_val("t1_busy",     64'(busy),     64'd1);
        run_traffic(50);
        check_val("t1_rdata_beef", 64'(rdata), 64'hBEEF);
        check_val("t1_busy_low",   64'(busy),  64'd0);
        check_val("t1_ack_low",    64'(ack),   64'd0);

        // 2: contention from reset, each requester one word at a time
        do_reset();
        words[0] = 2; words[1] = 2;
        base[0] = 32'h2000; base[1] = 32'h3000; wr_flag[1] = 1'b1;
        mem_delay = 1;
        ord = '{0, 1, 0, 1};
        foreach (ord[j]) push_expected(ord[j], 1'b0);
        run_traffic(100);

        // 3: burst lock of 4, requester 1 joins during word 1
        do_reset();
        words[0] = 10; hold[0] = 1'b1; base[0] = 32'h4000;
        words[1] = 1;  start_dly[1] = 2; base[1] = 32'h5000; wr_flag[1] = 1'b1;
        mem_delay = 0;
        ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        foreach (ord[j]) push_expected(ord[j], 1'b0);
        run_traffic(200);

        // 4: sole requester across burst boundaries, 3-cycle word period
        do_reset();
        words[0] = 6; hold[0] = 1'b1; base[0] = 32'h6000; wr_flag[0] = 1'b1;
        mem_delay = 0;
        period_chk = 1'b1;
        for (int j = 0; j < 6; j++) push_expected(0, 1'b0);
        run_traffic(100);
        period_chk = 1'b0;

        // 5: reset in the middle of an access, then a stray mem_ack
        do_reset();
        base[0] = 32'h500; mem_delay = 1000;
        push_grant(0);
        present(0);
        @(posedge clk); #1;
        check_val("t5_mem_req_up", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("t5_mem_req_drop", 64'(mem_req), 64'd0);
        check_val("t5_ack",          64'(ack),     64'd0);
        check_val("t5_busy",         64'(busy),    64'd0);
        req   = '0;
        reset = 1'b1;
        @(negedge clk); mem_force = 1'b1;
        @(negedge clk); mem_force = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check_val("t5_stray_ack", 64'(ack), 64'd0);
        end

`ifdef DMA_ARBITER_TIMEOUT_EN
        // 6: first access never acked, aborted after TIMEOUT cycles
        do_reset();
        words[0] = 2; hold[0] = 1'b1; base[0] = 32'h7000;
        words[1] = 1; base[1] = 32'h8000;
        mem_delay = 0; slow_n = 1;
        push_expected(0, 1'b1);
        push_expected(1, 1'b0);
        push_expected(0, 1'b0);
        run_traffic(100);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_val("exp_q_empty",   64'(exp_q.size()),   64'd0);
        check_val("grant_q_empty", 64'(grant_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
